// File: rtl/abuf2ddr.sv
// ============================================================================
// Module  : abuf2ddr
// Brief   : Streams one PE accumulation buffer (data or tail) out to a DDR
//           writer over valid/ready. Optional ABUF2DDR_CLEAR_EN adds a
//           per-entry clear strobe once the entry has been fully sent.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module abuf2ddr #(
    parameter int BUF_DEPTH = 256,
    parameter int PE_NUM    = 32,
    parameter int ADDR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    parameter int DDR_W     = 512,
    parameter int BATCH     = 32,
    parameter int DATA_W    = 16,
    parameter int TAIL_W    = 32,
    localparam int PE_W     = (PE_NUM > 1) ? $clog2(PE_NUM) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      done,
    input  logic                      conf_trans_type,
    input  logic [7:0]                conf_trans_num,
    input  logic [PE_W-1:0]           conf_pe_sel,
    output logic [ADDR_W-1:0]         abuf_rd_addr,
    output logic [PE_NUM-1:0]         abuf_rd_en,
    input  logic [BATCH*DATA_W-1:0]   abuf_rd_data,
    input  logic [BATCH*TAIL_W-1:0]   abuf_rd_tail,
`ifdef ABUF2DDR_CLEAR_EN
    output logic [ADDR_W-1:0]         abuf_clr_addr,
    output logic [PE_NUM-1:0]         abuf_clr_en,
`endif
    output logic [DDR_W-1:0]          ddr_data,
    output logic                      ddr_valid,
    input  logic                      ddr_ready
);

    localparam int TD_RATE = TAIL_W / DATA_W;
    localparam int KW      = (TD_RATE > 1) ? $clog2(TD_RATE) : 1;
    localparam int EW      = BATCH * TAIL_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [7:0]         num_q;
    logic               type_q;
    logic [PE_W-1:0]    pe_q;
    logic               pend_q;
    logic [1:0]         cnt_q, cnt_d;
    logic               wptr_q, rptr_q;
    logic [KW-1:0]      beat_q;
    logic [EW-1:0]      mem_q [2];

    logic               accept, issue, last_addr, acc, last_beat, pop;
    logic [2:0]         occ;
    logic [EW-1:0]      head;
    logic [PE_NUM-1:0]  pe_onehot;

    assign accept    = (state_q == S_IDLE) && start;
    assign ddr_valid = (cnt_q != 2'd0);
    assign acc       = ddr_valid && ddr_ready;
    assign last_beat = type_q ? (beat_q == KW'(TD_RATE - 1)) : 1'b1;
    assign pop       = acc && last_beat;
    // Occupancy after this cycle's pop, so reads keep flowing at full rate.
    assign occ       = {1'b0, cnt_q} + {2'b00, pend_q} - {2'b00, pop};
    assign issue     = (state_q == S_READ) && (occ < 3'd2);
    assign last_addr = (32'(addr_q) == 32'(num_q));
    assign cnt_d     = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    assign pe_onehot = PE_NUM'(1) << pe_q;
    assign head      = mem_q[rptr_q];

    assign done         = (state_q == S_IDLE);
    assign abuf_rd_addr = addr_q;
    assign abuf_rd_en   = issue ? pe_onehot : '0;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    addr_d  = '0;
                end
            end
            S_READ: begin
                if (issue) begin
                    if (last_addr) state_d = S_DRAIN;
                    else           addr_d  = addr_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (!pend_q && (cnt_d == 2'd0)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ddr_data = '0;
        if (!type_q) begin
            ddr_data = head[DDR_W-1:0];
        end else begin
            for (int b = 0; b < BATCH; b++) begin
                ddr_data[b*DATA_W +: DATA_W] = head[b*TAIL_W + int'(beat_q)*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            num_q   <= '0;
            type_q  <= 1'b0;
            pe_q    <= '0;
            pend_q  <= 1'b0;
            cnt_q   <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= issue;
            cnt_q   <= cnt_d;
            if (accept) begin
                num_q  <= conf_trans_num;
                type_q <= conf_trans_type;
                pe_q   <= conf_pe_sel;
            end
            if (pend_q) wptr_q <= ~wptr_q;
            if (pop)    rptr_q <= ~rptr_q;
            if (acc)    beat_q <= last_beat ? '0 : beat_q + 1'b1;
        end
    end

    // Skid storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (pend_q) mem_q[wptr_q] <= type_q ? abuf_rd_tail : EW'(abuf_rd_data);
    end

`ifdef ABUF2DDR_CLEAR_EN
    logic [ADDR_W-1:0] pend_addr_q;
    logic [ADDR_W-1:0] ent_addr_q [2];
    logic [ADDR_W-1:0] clr_addr_q;
    logic [PE_NUM-1:0] clr_en_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_addr_q <= '0;
            clr_addr_q  <= '0;
            clr_en_q    <= '0;
        end else begin
            if (issue) pend_addr_q <= addr_q;
            clr_en_q <= pop ? pe_onehot : '0;
            if (pop) clr_addr_q <= ent_addr_q[rptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (pend_q) ent_addr_q[wptr_q] <= pend_addr_q;
    end

    assign abuf_clr_addr = clr_addr_q;
    assign abuf_clr_en   = clr_en_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_abuf2ddr.sv
// Randomized scoreboard bench for abuf2ddr: a buffer model feeds reads, an
// expected-beat queue is built per job and a negedge monitor checks output.
`default_nettype none

module tb_abuf2ddr;

    localparam int DDR_W  = 512;
    localparam int BATCH  = 32;
    localparam int DATA_W = 16;
    localparam int TAIL_W = 32;
    localparam int PE_NUM = 32;
    localparam int ADDR_W = 8;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    start = 1'b0;
    logic                    done;
    logic                    conf_trans_type = 1'b0;
    logic [7:0]              conf_trans_num = '0;
    logic [4:0]              conf_pe_sel = '0;
    logic [ADDR_W-1:0]       abuf_rd_addr;
    logic [PE_NUM-1:0]       abuf_rd_en;
    logic [BATCH*DATA_W-1:0] abuf_rd_data = '0;
    logic [BATCH*TAIL_W-1:0] abuf_rd_tail = '0;
    logic [DDR_W-1:0]        ddr_data;
    logic                    ddr_valid;
    logic                    ddr_ready = 1'b1;
`ifdef ABUF2DDR_CLEAR_EN
    logic [ADDR_W-1:0]       abuf_clr_addr;
    logic [PE_NUM-1:0]       abuf_clr_en;
`endif

    abuf2ddr dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .done            (done),
        .conf_trans_type (conf_trans_type),
        .conf_trans_num  (conf_trans_num),
        .conf_pe_sel     (conf_pe_sel),
        .abuf_rd_addr    (abuf_rd_addr),
        .abuf_rd_en      (abuf_rd_en),
        .abuf_rd_data    (abuf_rd_data),
        .abuf_rd_tail    (abuf_rd_tail),
`ifdef ABUF2DDR_CLEAR_EN
        .abuf_clr_addr   (abuf_clr_addr),
        .abuf_clr_en     (abuf_clr_en),
`endif
        .ddr_data        (ddr_data),
        .ddr_valid       (ddr_valid),
        .ddr_ready       (ddr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DDR_W-1:0] d;
        bit               last_e;
        int               addr;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    seed = 0;
    int    cur_pe = 0;
    int    cur_num = 0;
    int    exp_addr = 0;
    int    s_cyc = 0;
    int    last_acc_cyc = 0;
    int    rmode_g = 1;
    bit    job_active = 0;
    bit    first_seen = 0;
    bit    have_prev_acc = 0;
    bit    chk_done_next = 0;
    bit    stall_prev = 0;
    bit    clr_pending = 0;
    int    clr_addr_exp = 0;
    logic [DDR_W-1:0] prev_data = '0;

    task automatic chk_int(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic chk_vec(string name, logic [DDR_W-1:0] act, logic [DDR_W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [BATCH*DATA_W-1:0] mk_data(int pe, int addr, int sd);
        logic [BATCH*DATA_W-1:0] r;
        for (int b = 0; b < BATCH; b++)
            r[b*DATA_W +: DATA_W] = DATA_W'(sd + pe*4099 + addr*257 + b*31 + b*addr);
        return r;
    endfunction

    function automatic logic [BATCH*TAIL_W-1:0] mk_tail(int pe, int addr, int sd);
        logic [BATCH*TAIL_W-1:0] r;
        for (int b = 0; b < BATCH; b++)
            r[b*TAIL_W +: TAIL_W] = TAIL_W'((sd*7) ^ (pe << 24) ^ (addr << 12) ^ (b*40503) ^ (b << 20));
        return r;
    endfunction

    // Reference: entries 0..num; tail entries split into DATA_W slices, low first.
    task automatic push_expected(bit ttype, int num, int pe);
        beat_t bt;
        logic [BATCH*TAIL_W-1:0] t;
        for (int e = 0; e <= num; e++) begin
            if (!ttype) begin
                bt.d = mk_data(pe, e, seed);
                bt.last_e = 1'b1;
                bt.addr = e;
                exp_q.push_back(bt);
            end else begin
                t = mk_tail(pe, e, seed);
                for (int k = 0; k < TAIL_W/DATA_W; k++) begin
                    for (int b = 0; b < BATCH; b++)
                        bt.d[b*DATA_W +: DATA_W] = t[b*TAIL_W + k*DATA_W +: DATA_W];
                    bt.last_e = (k == TAIL_W/DATA_W - 1);
                    bt.addr = e;
                    exp_q.push_back(bt);
                end
            end
        end
    endtask

    // Accumulation buffer model: selected PE entry valid one cycle after strobe.
    always @(posedge clk) begin
        int sel;
        logic [BATCH*DATA_W-1:0] jd;
        logic [BATCH*TAIL_W-1:0] jt;
        sel = -1;
        for (int i = 0; i < PE_NUM; i++) if (abuf_rd_en[i]) sel = i;
        if (sel >= 0) begin
            abuf_rd_data <= mk_data(sel, int'(abuf_rd_addr), seed);
            abuf_rd_tail <= mk_tail(sel, int'(abuf_rd_addr), seed);
        end else begin
            for (int i = 0; i < BATCH*DATA_W/32; i++) jd[i*32 +: 32] = $urandom;
            for (int i = 0; i < BATCH*TAIL_W/32; i++) jt[i*32 +: 32] = $urandom;
            abuf_rd_data <= jd;
            abuf_rd_tail <= jt;
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rmode_g == 0)      ddr_ready = 1'b0;
        else if (rmode_g == 1) ddr_ready = 1'b1;
        else                   ddr_ready = 1'($urandom % 2);
    end

    always @(negedge clk) begin
        beat_t bt;
        if (!rst) begin
            stall_prev = 0;
            chk_done_next = 0;
            clr_pending = 0;
        end else begin
            if (abuf_rd_en != '0) begin
                if (!job_active) begin
                    chk_int("read strobe while no job", longint'(abuf_rd_en), 0);
                end else begin
                    chk_int("rd_en onehot", longint'(abuf_rd_en), longint'(1) << cur_pe);
                    chk_int("rd_addr order", abuf_rd_addr, exp_addr);
                    chk_int("rd_addr within num", abuf_rd_addr <= cur_num, 1);
                    exp_addr++;
                end
            end
            if (chk_done_next) begin
                chk_int("done after last beat", done, 1);
                chk_done_next = 0;
            end
`ifdef ABUF2DDR_CLEAR_EN
            if (clr_pending) begin
                chk_int("clr_en onehot", longint'(abuf_clr_en), longint'(1) << cur_pe);
                chk_int("clr_addr", abuf_clr_addr, clr_addr_exp);
                clr_pending = 0;
            end else if (abuf_clr_en != '0) begin
                chk_int("spurious clr_en", longint'(abuf_clr_en), 0);
            end
`endif
            if (stall_prev && !ddr_valid) chk_int("valid held while stalled", ddr_valid, 1);
            if (ddr_valid) begin
                if (stall_prev) chk_vec("data stable while stalled", ddr_data, prev_data);
                if (!first_seen && job_active) begin
                    chk_int("first valid latency<=3", (cyc - s_cyc) <= 3, 1);
                    first_seen = 1;
                end
                if (exp_q.size() == 0) begin
                    chk_int("spurious beat", ddr_valid, 0);
                end else if (ddr_ready) begin
                    bt = exp_q.pop_front();
                    chk_vec("beat data", ddr_data, bt.d);
                    if (rmode_g == 1 && have_prev_acc)
                        chk_int("back-to-back beats", cyc, last_acc_cyc + 1);
                    last_acc_cyc = cyc;
                    have_prev_acc = 1;
                    if (exp_q.size() == 0) chk_done_next = 1;
                    else chk_int("done low mid-job", done, 0);
                    if (bt.last_e) begin
                        clr_pending = 1;
                        clr_addr_exp = bt.addr;
                    end
                end
                stall_prev = !ddr_ready;
                prev_data = ddr_data;
            end else begin
                stall_prev = 0;
            end
        end
    end

    task automatic launch(bit ttype, int num, int pe, int rmode);
        seed = int'($urandom);
        cur_pe = pe;
        cur_num = num;
        exp_addr = 0;
        first_seen = 0;
        have_prev_acc = 0;
        job_active = 1;
        rmode_g = rmode;
        push_expected(ttype, num, pe);
        conf_trans_type = ttype;
        conf_trans_num = 8'(num);
        conf_pe_sel = 5'(pe);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        s_cyc = cyc;
        conf_trans_type = 1'($urandom);
        conf_trans_num = 8'($urandom);
        conf_pe_sel = 5'($urandom);
    endtask

    task automatic run_job(bit ttype, int num, int pe, int rmode, bit busy_start);
        bit ok;
        launch(ttype, num, pe, rmode);
        if (busy_start) begin
            chk_int("done low while busy", done, 0);
            conf_trans_type = ~ttype;
            conf_trans_num = 8'(num + 3);
            conf_pe_sel = 5'(pe + 1);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (done && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        chk_int("job completes in budget", ok, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_int("all beats delivered", exp_q.size(), 0);
        chk_int("reads issued", exp_addr, num + 1);
        exp_q.delete();
        job_active = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_int("reset done", done, 1);
        chk_int("reset ddr_valid", ddr_valid, 0);
        chk_int("reset rd_en", longint'(abuf_rd_en), 0);
        chk_int("reset rd_addr", abuf_rd_addr, 0);
`ifdef ABUF2DDR_CLEAR_EN
        chk_int("reset clr_en", longint'(abuf_clr_en), 0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_job(1'b0, 3, 5, 1, 1'b0);
        run_job(1'b1, 1, 9, 1, 1'b0);
        run_job(1'b0, 7, 12, 2, 1'b0);
        run_job(1'b0, 0, 31, 1, 1'b0);
        run_job(1'b1, 0, 0, 2, 1'b0);
        run_job(1'b0, 2, 17, 1, 1'b0);
        run_job(1'b0, 5, 2, 1, 1'b1);
        run_job(1'b1, 3, 4, 2, 1'b1);
        for (int j = 0; j < 8; j++)
            run_job(1'($urandom), int'($urandom_range(0, 20)), int'($urandom_range(0, 31)),
                    int'($urandom_range(1, 2)), 1'b0);
        run_job(1'b0, 255, 30, 2, 1'b0);

        // Abandon a stalled job with a mid-job reset.
        launch(1'b0, 20, 3, 0);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_int("mid-job reset ddr_valid", ddr_valid, 0);
        chk_int("mid-job reset done", done, 1);
        chk_int("mid-job reset rd_en", longint'(abuf_rd_en), 0);
        chk_int("mid-job reset rd_addr", abuf_rd_addr, 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        job_active = 0;
        rmode_g = 1;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk_int("idle after reset", done, 1);

        run_job(1'b1, 2, 6, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
